jtag_chain_hub: RTL and testbench
=================================

# jtag_chain_hub

Parametrised JTAG user-chain hub sitting directly behind the JTAGG primitive's user-register interface. It generalises the fixed two-chain wrapper to NUM_CHAINS independent data registers of DR_WIDTH bits each. Every chain supports capture, LSB-first shift and length-checked update. Each chain provides a registered parallel output, one-cycle update and run-test-idle strobes, and a sticky length-error flag.

## Interface
- NUM_CHAINS, 2: number of user chains (1..8); bit i of JCE/JRTI/JTDO maps to chain i.
- DR_WIDTH, 9: data-register length per chain (2..32).
- RESET_VALUE, 0: DR_WIDTH-bit reset value of every chain's parallel output register.

Ports:
- JTCK  in  1  JTAG clock; all state on rising edge.
- JRST  in  1  reset; asynchronous, active-high.
- JTDI  in  1  serial data in, shared by all chains.
- JSHIFT  in  1  TAP in Shift-DR.
- JUPDATE  in  1  TAP in Update-DR.
- JCE  in  NUM_CHAINS  per-chain enable, high during Capture-DR and Shift-DR of that chain's ER instruction.
- JRTI  in  NUM_CHAINS  per-chain Run-Test/Idle indication.
- CAP_IN  in  NUM_CHAINS*DR_WIDTH  capture data, chain i at [i*DR_WIDTH +: DR_WIDTH]; used only with the configuration macro.
- JTDO  out  NUM_CHAINS  serial out per chain, equal to bit 0 of that chain's shift register.
- DR_OUT  out  NUM_CHAINS*DR_WIDTH  committed parallel registers; same packing as CAP_IN.
- UPDATE_STB  out  NUM_CHAINS  one-cycle pulse when a chain commits.
- RTI_STB  out  NUM_CHAINS  one-cycle pulse on the rising edge of JRTI[i].
- LEN_ERR  out  NUM_CHAINS  sticky; set when an update has a wrong shift length.

## Operation
- Chain select: sampled on each JCE assertion. If several JCE bits are high, the lowest index wins and the others are ignored. The selected index is held in a register until return to IDLE.
- FSM, one instance shared across chains:
  - IDLE: JCE≠0 and JSHIFT=0 → CAPTURE. Load the selected shift register, clear the bit counter, latch the select index.
  - CAPTURE: JCE[sel]&JSHIFT → SHIFT. JCE[sel] low → WAIT_UPD.
  - SHIFT: each cycle with JCE[sel]&JSHIFT, sr ← {JTDI, sr[DR_WIDTH-1:1]}. The counter increments and saturates at DR_WIDTH+1. JCE[sel] or JSHIFT low → WAIT_UPD.
  - WAIT_UPD: JUPDATE=1 → IDLE.
    - If counter==DR_WIDTH: DR_OUT[sel] ← sr, UPDATE_STB[sel]=1 for one cycle, LEN_ERR[sel] cleared.
    - Otherwise: no commit and LEN_ERR[sel] set.
- JUPDATE in IDLE, CAPTURE or SHIFT: ignored.
- Entering capture directly from Shift-DR with JSHIFT already high (no capture cycle): treated as CAPTURE with the load skipped. The counter is still cleared.
- Non-selected shift registers hold their value.
- Counter width: clog2(DR_WIDTH+2).
- RTI_STB: per chain, JRTI registered once; pulse = JRTI & ~JRTI_q. Fully independent of the FSM.

## Timing
- Reset values:
  - Every DR_OUT slice = RESET_VALUE.
  - All shift registers = 0, so JTDO = 0.
  - UPDATE_STB, RTI_STB and LEN_ERR = 0.
  - FSM = IDLE, select = 0, counter = 0.
- JRST asserted mid-shift or mid-update aborts the operation. No commit occurs and no strobe is emitted.
- Capture load is visible on JTDO one JTCK after the capture edge. Each shift edge updates JTDO on the same edge.
- DR_OUT and UPDATE_STB change on the JTCK edge where JUPDATE is sampled high in WAIT_UPD, giving one-cycle latency from Update-DR.
- RTI_STB rises one edge after JRTI rises and lasts exactly one cycle. JRTI held high gives a single pulse.
- Shift of exactly DR_WIDTH bits commits. DR_WIDTH-1 or DR_WIDTH+1 bits sets LEN_ERR. Counter saturation means longer shifts never alias to a valid length.

## Configuration
- JTAG_CHAIN_HUB_CAPTURE_EN
  - Defined: capture loads CAP_IN[sel], for host readback of device status.
  - Undefined: capture loads DR_OUT[sel], so the host reads back the last committed value. CAP_IN is ignored.

## Test plan
- Reset: assert JRST mid-shift on chain 1 → DR_OUT all RESET_VALUE, JTDO=0, no UPDATE_STB, FSM idle next cycle.
- Nominal write, DR_WIDTH=9:
  - Stimulus: capture then shift 9'h1A5 LSB-first on chain 0, then update.
  - Response: DR_OUT[0]=9'h1A5, UPDATE_STB=2'b01 for one cycle, chain 1 unchanged.
- Short/long shift: shift 8 bits, then 10 bits, on chain 1 → no commit either time, LEN_ERR[1]=1. A subsequent 9-bit shift commits and clears LEN_ERR[1].
- Readback:
  - Macro undefined: after writing 9'h0F3, the next capture+9 shifts emits 1,1,0,0,1,1,1,1,0 on JTDO[0].
  - Macro defined: CAP_IN chain 0 = 9'h155 is shifted out instead.
- Simultaneous JCE=2'b11 → only chain 0 captures/shifts/commits. JTDO[1] is constant.
- RTI: JRTI[1] high 5 cycles → exactly one RTI_STB[1] pulse, one cycle after the rise. RTI_STB[0] stays 0.

Source files
------------

// File: rtl/jtag_chain_hub_if.sv
// Signal bundle between the JTAGG user-register side (master) and jtag_chain_hub (slave).
// Clock and reset stay outside the bundle as plain ports of the hub.
interface jtag_chain_hub_if #(
    parameter int NUM_CHAINS = 2,
    parameter int DR_WIDTH   = 9
);
    logic                           JTDI;
    logic                           JSHIFT;
    logic                           JUPDATE;
    logic [NUM_CHAINS-1:0]          JCE;
    logic [NUM_CHAINS-1:0]          JRTI;
    logic [NUM_CHAINS*DR_WIDTH-1:0] CAP_IN;
    logic [NUM_CHAINS-1:0]          JTDO;
    logic [NUM_CHAINS*DR_WIDTH-1:0] DR_OUT;
    logic [NUM_CHAINS-1:0]          UPDATE_STB;
    logic [NUM_CHAINS-1:0]          RTI_STB;
    logic [NUM_CHAINS-1:0]          LEN_ERR;

    modport master (
        output JTDI, JSHIFT, JUPDATE, JCE, JRTI, CAP_IN,
        input  JTDO, DR_OUT, UPDATE_STB, RTI_STB, LEN_ERR
    );

    modport slave (
        input  JTDI, JSHIFT, JUPDATE, JCE, JRTI, CAP_IN,
        output JTDO, DR_OUT, UPDATE_STB, RTI_STB, LEN_ERR
    );
endinterface

// File: rtl/jtag_chain_hub.sv
// NUM_CHAINS user data registers behind JTAGG with capture, LSB-first shift and length-checked update.
// Define JTAG_CHAIN_HUB_CAPTURE_EN to capture CAP_IN instead of reading back the committed DR_OUT.
module jtag_chain_hub #(
    parameter int                    NUM_CHAINS  = 2,
    parameter int                    DR_WIDTH    = 9,
    parameter logic [DR_WIDTH-1:0]   RESET_VALUE = '0
) (
    input  logic               JTCK,
    input  logic               JRST,
    jtag_chain_hub_if.slave    bus
);
    localparam int SEL_W = (NUM_CHAINS > 1) ? $clog2(NUM_CHAINS) : 1;
    localparam int CNT_W = $clog2(DR_WIDTH + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DR_WIDTH);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(DR_WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_SHIFT,
        ST_WAIT_UPD
    } state_t;

    state_t                  state_q, state_d;
    logic [SEL_W-1:0]        sel_q, sel_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DR_WIDTH-1:0]     sr_q [NUM_CHAINS];
    logic [DR_WIDTH-1:0]     dr_q [NUM_CHAINS];
    logic [NUM_CHAINS-1:0]   upd_stb_q;
    logic [NUM_CHAINS-1:0]   len_err_q;
    logic [NUM_CHAINS-1:0]   jrti_q;
    logic [NUM_CHAINS-1:0]   rti_stb_q;
    logic                    load_en;
    logic                    shift_en;
    logic                    commit;
    logic                    len_fail;
    logic [DR_WIDTH-1:0]     cap_val;

    // Lowest set JCE bit wins when several chains are enabled at once.
    function automatic logic [SEL_W-1:0] lowest_index(input logic [NUM_CHAINS-1:0] ce);
        lowest_index = '0;
        for (int i = NUM_CHAINS - 1; i >= 0; i--) begin
            if (ce[i]) lowest_index = SEL_W'(i);
        end
    endfunction

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        cnt_d    = cnt_q;
        load_en  = 1'b0;
        shift_en = 1'b0;
        commit   = 1'b0;
        len_fail = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (|bus.JCE) begin
                    sel_d   = lowest_index(bus.JCE);
                    cnt_d   = '0;
                    load_en = !bus.JSHIFT;
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE, ST_SHIFT: begin
                if (bus.JCE[sel_q] && bus.JSHIFT) begin
                    shift_en = 1'b1;
                    cnt_d    = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;
                    state_d  = ST_SHIFT;
                end else if (!bus.JCE[sel_q] || state_q == ST_SHIFT) begin
                    state_d = ST_WAIT_UPD;
                end
            end
            ST_WAIT_UPD: begin
                if (bus.JUPDATE) begin
                    state_d  = ST_IDLE;
                    commit   = (cnt_q == CNT_FULL);
                    len_fail = (cnt_q != CNT_FULL);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef JTAG_CHAIN_HUB_CAPTURE_EN
    assign cap_val = bus.CAP_IN[sel_d*DR_WIDTH +: DR_WIDTH];
`else
    logic unused_cap_in;
    assign unused_cap_in = ^bus.CAP_IN;
    assign cap_val       = dr_q[sel_d];
`endif

    always_ff @(posedge JTCK or posedge JRST) begin
        if (JRST) begin
            state_q   <= ST_IDLE;
            sel_q     <= '0;
            cnt_q     <= '0;
            upd_stb_q <= '0;
            len_err_q <= '0;
            jrti_q    <= '0;
            rti_stb_q <= '0;
            for (int i = 0; i < NUM_CHAINS; i++) begin
                sr_q[i] <= '0;
                dr_q[i] <= RESET_VALUE;
            end
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            cnt_q     <= cnt_d;
            jrti_q    <= bus.JRTI;
            rti_stb_q <= bus.JRTI & ~jrti_q;
            upd_stb_q <= '0;
            if (load_en) sr_q[sel_d] <= cap_val;
            if (shift_en) sr_q[sel_q] <= {bus.JTDI, sr_q[sel_q][DR_WIDTH-1:1]};
            if (commit) begin
                dr_q[sel_q]      <= sr_q[sel_q];
                upd_stb_q[sel_q] <= 1'b1;
                len_err_q[sel_q] <= 1'b0;
            end
            if (len_fail) len_err_q[sel_q] <= 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_CHAINS; g++) begin : g_chain
        assign bus.JTDO[g]                         = sr_q[g][0];
        assign bus.DR_OUT[g*DR_WIDTH +: DR_WIDTH] = dr_q[g];
    end

    assign bus.UPDATE_STB = upd_stb_q;
    assign bus.RTI_STB    = rti_stb_q;
    assign bus.LEN_ERR    = len_err_q;
endmodule

// File: tb/tb_jtag_chain_hub.sv
// Directed + randomized bench for jtag_chain_hub; models each chain's DR as a bit queue.
module tb_jtag_chain_hub;
    localparam int NC = 2;
    localparam int W  = 9;
    localparam logic [W-1:0] RST_VAL = 9'h12C;

    logic JTCK;
    logic JRST;
    int   checks;
    int   failures;

    logic [W-1:0]  exp_dr [NC];
    logic [W-1:0]  held   [NC];
    logic [W-1:0]  cap_in [NC];
    logic [NC-1:0] exp_len;
    logic [W-1:0]  last_out;

    jtag_chain_hub_if #(.NUM_CHAINS(NC), .DR_WIDTH(W)) bus ();

    jtag_chain_hub #(
        .NUM_CHAINS (NC),
        .DR_WIDTH   (W),
        .RESET_VALUE(RST_VAL)
    ) dut (
        .JTCK(JTCK),
        .JRST(JRST),
        .bus (bus)
    );

    initial JTCK = 1'b0;
    always #5 JTCK = ~JTCK;

    task automatic tick();
        @(posedge JTCK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NC*W-1:0] dr_vec();
        logic [NC*W-1:0] v;
        for (int c = 0; c < NC; c++) v[c*W +: W] = exp_dr[c];
        return v;
    endfunction

    function automatic logic [NC-1:0] held_tdo();
        logic [NC-1:0] v;
        for (int c = 0; c < NC; c++) v[c] = held[c][0];
        return v;
    endfunction

    function automatic logic [W-1:0] capture_value(input int sel);
`ifdef JTAG_CHAIN_HUB_CAPTURE_EN
        return cap_in[sel];
`else
        return exp_dr[sel];
`endif
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NC; c++) begin
            exp_dr[c] = RST_VAL;
            held[c]   = '0;
        end
        exp_len = '0;
    endtask

    // One full DR scan: capture (or direct entry), n shift edges, exit, update.
    task automatic scan(input logic [NC-1:0] mask, input int n, input logic [31:0] data,
                        input bit skip_cap);
        int            sel;
        bit            q[$];
        logic [W-1:0]  start;
        logic [NC-1:0] tv;
        logic [NC-1:0] exp_stb;
        sel = 0;
        for (int i = NC - 1; i >= 0; i--) if (mask[i]) sel = i;
        start = skip_cap ? held[sel] : capture_value(sel);
        bus.JCE    = mask;
        bus.JSHIFT = skip_cap;
        tick();
        q = {};
        for (int i = 0; i < W; i++) q.push_back(start[i]);
        bus.JSHIFT = 1'b1;
        last_out   = '0;
        for (int k = 0; k < n; k++) begin
            tv = held_tdo();
            tv[sel] = q[0];
            chk("jtdo_shift", 32'(bus.JTDO), 32'(tv));
            if (k < W) last_out[k] = bus.JTDO[sel];
            bus.JTDI = data[k];
            tick();
            void'(q.pop_front());
            q.push_back(data[k]);
        end
        for (int i = 0; i < W; i++) held[sel][i] = q[i];
        bus.JCE    = '0;
        bus.JSHIFT = 1'b0;
        bus.JTDI   = 1'b0;
        tick();
        chk("stb_before_upd", 32'(bus.UPDATE_STB), 32'd0);
        chk("jtdo_exit", 32'(bus.JTDO), 32'(held_tdo()));
        bus.JUPDATE = 1'b1;
        tick();
        bus.JUPDATE = 1'b0;
        exp_stb = '0;
        if (n == W) begin
            exp_dr[sel]  = held[sel];
            exp_len[sel] = 1'b0;
            exp_stb[sel] = 1'b1;
        end else begin
            exp_len[sel] = 1'b1;
        end
        chk("dr_out", 32'(bus.DR_OUT), 32'(dr_vec()));
        chk("update_stb", 32'(bus.UPDATE_STB), 32'(exp_stb));
        chk("len_err", 32'(bus.LEN_ERR), 32'(exp_len));
        tick();
        chk("update_stb_clear", 32'(bus.UPDATE_STB), 32'd0);
    endtask

    initial begin
        int            lens[4];
        logic [NC-1:0] rti_prev;
        logic [NC-1:0] rti_cur;
        checks      = 0;
        failures    = 0;
        cap_in[0]   = 9'h155;
        cap_in[1]   = 9'h0AA;
        bus.JTDI    = 1'b0;
        bus.JSHIFT  = 1'b0;
        bus.JUPDATE = 1'b0;
        bus.JCE     = '0;
        bus.JRTI    = '0;
        bus.CAP_IN  = {cap_in[1], cap_in[0]};
        JRST        = 1'b1;
        model_reset();
        tick();
        tick();
        chk("rst_dr_out", 32'(bus.DR_OUT), 32'(dr_vec()));
        chk("rst_jtdo", 32'(bus.JTDO), 32'd0);
        chk("rst_update_stb", 32'(bus.UPDATE_STB), 32'd0);
        chk("rst_rti_stb", 32'(bus.RTI_STB), 32'd0);
        chk("rst_len_err", 32'(bus.LEN_ERR), 32'd0);
        JRST = 1'b0;
        tick();

        // Nominal write of 0x1A5 to chain 0; chain 1 must stay at reset value.
        scan(2'b01, W, 32'h1A5, 1'b0);
        chk("nominal_dr0", 32'(bus.DR_OUT[W-1:0]), 32'h1A5);
        chk("nominal_dr1", 32'(bus.DR_OUT[2*W-1:W]), 32'(RST_VAL));

        // Short and long shifts on chain 1, then a correct one.
        scan(2'b10, W - 1, 32'h0FF, 1'b0);
        chk("short_len_err1", 32'(bus.LEN_ERR[1]), 32'd1);
        scan(2'b10, W + 1, 32'h2CB, 1'b0);
        chk("long_len_err1", 32'(bus.LEN_ERR[1]), 32'd1);
        chk("long_dr1", 32'(bus.DR_OUT[2*W-1:W]), 32'(RST_VAL));
        scan(2'b10, W, 32'h07E, 1'b0);
        chk("fix_len_err1", 32'(bus.LEN_ERR[1]), 32'd0);
        chk("fix_dr1", 32'(bus.DR_OUT[2*W-1:W]), 32'h07E);

        // Readback of the captured value on JTDO[0].
        scan(2'b01, W, 32'h0F3, 1'b0);
        scan(2'b01, W, 32'h000, 1'b0);
`ifdef JTAG_CHAIN_HUB_CAPTURE_EN
        chk("readback_seq", 32'(last_out), 32'h155);
`else
        chk("readback_seq", 32'(last_out), 32'h0F3);
`endif

        // Both enables high: chain 0 wins.
        scan(2'b11, W, 32'h16D, 1'b0);
        chk("dual_ce_dr0", 32'(bus.DR_OUT[W-1:0]), 32'h16D);
        chk("dual_ce_dr1", 32'(bus.DR_OUT[2*W-1:W]), 32'h07E);

        // Direct entry into shift without a capture cycle.
        scan(2'b10, W, 32'h133, 1'b1);
        chk("direct_dr1", 32'(bus.DR_OUT[2*W-1:W]), 32'h133);

        // Randomized scans.
        lens[0] = W - 1;
        lens[1] = W;
        lens[2] = W + 1;
        lens[3] = W + 4;
        for (int it = 0; it < 16; it++) begin
            scan(NC'($urandom_range(1, 3)), lens[$urandom_range(0, 3)], $urandom,
                 ($urandom_range(0, 3) == 0));
        end

        // Reset in the middle of a shift on chain 1.
        bus.JCE    = 2'b10;
        bus.JSHIFT = 1'b0;
        tick();
        bus.JSHIFT = 1'b1;
        bus.JTDI   = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        JRST = 1'b1;
        #2;
        model_reset();
        chk("midrst_dr_out", 32'(bus.DR_OUT), 32'(dr_vec()));
        chk("midrst_jtdo", 32'(bus.JTDO), 32'd0);
        chk("midrst_len_err", 32'(bus.LEN_ERR), 32'd0);
        bus.JCE    = '0;
        bus.JSHIFT = 1'b0;
        bus.JTDI   = 1'b0;
        tick();
        JRST = 1'b0;
        tick();
        bus.JUPDATE = 1'b1;
        tick();
        bus.JUPDATE = 1'b0;
        chk("midrst_no_stb", 32'(bus.UPDATE_STB), 32'd0);
        chk("midrst_no_commit", 32'(bus.DR_OUT), 32'(dr_vec()));
        tick();
        scan(2'b10, W, 32'h0C9, 1'b0);

        // RTI strobes: JRTI[1] held for 5 cycles, then random patterns.
        rti_prev = '0;
        for (int k = 0; k < 8; k++) begin
            rti_cur  = (k < 5) ? 2'b10 : 2'b00;
            bus.JRTI = rti_cur;
            tick();
            chk("rti_hold", 32'(bus.RTI_STB), 32'(rti_cur & ~rti_prev));
            rti_prev = rti_cur;
        end
        for (int k = 0; k < 20; k++) begin
            rti_cur  = NC'($urandom_range(0, 3));
            bus.JRTI = rti_cur;
            tick();
            chk("rti_rand", 32'(bus.RTI_STB), 32'(rti_cur & ~rti_prev));
            rti_prev = rti_cur;
        end
        bus.JRTI = '0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
